// File: rtl/encoder_16to4_rr.sv
// Purpose : serializes an accepted request vector into one 4-bit index per set
//           bit, round-robin from a persistent pointer (inverse of the decoder).
// Latency : first index is registered one cycle after accept; then one index
//           per output handshake with no bubbles.
// Backpr. : in_ready is low while draining; out/out_last hold while
//           out_valid && !out_ready.
// Ports   : clk, reset_n (async active-low)
//           in[15:0], in_valid, in_ready        request vector handshake
//           out[3:0], out_valid, out_ready      index handshake
//           out_last                            final pending bit of vector
//           zero_vec                            1-cycle pulse: empty vector accepted
module encoder_16to4_rr #(
   parameter int N_REQ = 16
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [N_REQ-1:0]         in,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [$clog2(N_REQ)-1:0] out,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     out_last,
   output logic                     zero_vec
);

   localparam int IDX_W = $clog2(N_REQ);

   typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_t;

   state_t             state_q;
   logic [N_REQ-1:0]   pending_q;
   logic [IDX_W-1:0]   rr_ptr_q;
   logic [IDX_W-1:0]   out_q;
   logic               out_valid_q;
   logic               out_last_q;
   logic               zero_vec_q;

   // Next-state helpers for the two places a new index is chosen.
   logic [N_REQ-1:0]   pending_d;     // pending with the presented bit cleared
   logic [IDX_W-1:0]   rr_ptr_d;      // pointer after the current handshake
   logic [IDX_W-1:0]   acc_idx_d;     // first index of an incoming vector
   logic               acc_last_d;
   logic [IDX_W-1:0]   drn_idx_d;     // next index while draining
   logic               drn_last_d;

   // Lowest set bit at or above ptr, wrapping past the top index.
   function automatic logic [IDX_W-1:0] pick(input logic [N_REQ-1:0] vec,
                                             input logic [IDX_W-1:0] ptr);
      logic [IDX_W-1:0] k;
      logic [IDX_W-1:0] res;
      logic             found;
      res   = ptr;
      found = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         k = ptr + IDX_W'(i);
         if (!found && vec[k]) begin
            res   = k;
            found = 1'b1;
         end
      end
      return res;
   endfunction

   function automatic logic one_hot(input logic [N_REQ-1:0] vec);
      return (vec != '0) && ((vec & (vec - 1'b1)) == '0);
   endfunction

   always_comb begin
      pending_d  = pending_q & ~(N_REQ'(1) << out_q);
      rr_ptr_d   = out_q + 1'b1;
      acc_idx_d  = pick(in, rr_ptr_q);
      acc_last_d = one_hot(in);
      drn_idx_d  = pick(pending_d, rr_ptr_d);
      drn_last_d = one_hot(pending_d);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         pending_q   <= '0;
         rr_ptr_q    <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         zero_vec_q  <= 1'b0;
      end else begin
         zero_vec_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  if (in != '0) begin
                     pending_q   <= in;
                     out_q       <= acc_idx_d;
                     out_valid_q <= 1'b1;
                     out_last_q  <= acc_last_d;
                     state_q     <= DRAIN;
                  end else begin
                     zero_vec_q  <= 1'b1;
                  end
               end
            end
            DRAIN: begin
               // in/in_valid are deliberately ignored here.
               if (out_valid_q && out_ready) begin
                  pending_q <= pending_d;
                  rr_ptr_q  <= rr_ptr_d;
                  if (out_last_q) begin
                     state_q     <= IDLE;
                     out_q       <= '0;
                     out_valid_q <= 1'b0;
                     out_last_q  <= 1'b0;
                  end else begin
                     out_q       <= drn_idx_d;
                     out_last_q  <= drn_last_d;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // in_ready is decoded straight from the state register so reset forces it
   // high immediately.
   assign in_ready  = (state_q == IDLE);
   assign out       = out_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign zero_vec  = zero_vec_q;

endmodule

// File: tb/tb_encoder_16to4_rr.sv
// Bench for encoder_16to4_rr: expected {out_last,out} pairs are queued when a
// vector is driven and compared whenever the DUT completes an output handshake.
module tb_encoder_16to4_rr;

   logic        clk;
   logic        reset_n;
   logic [15:0] tb_in;
   logic        tb_in_valid;
   logic        tb_in_ready;
   logic [3:0]  tb_out;
   logic        tb_out_valid;
   logic        tb_out_ready;
   logic        tb_out_last;
   logic        tb_zero_vec;

   int          n_chk  = 0;
   int          n_pass = 0;
   logic [4:0]  exp_q[$];   // {last, idx}

   encoder_16to4_rr #(.N_REQ(16)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in        (tb_in),
      .in_valid  (tb_in_valid),
      .in_ready  (tb_in_ready),
      .out       (tb_out),
      .out_valid (tb_out_valid),
      .out_ready (tb_out_ready),
      .out_last  (tb_out_last),
      .zero_vec  (tb_zero_vec)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [3:0] idx, input logic last);
      exp_q.push_back({last, idx});
   endtask

   // Waits (bounded) for in_ready, then presents v for exactly one edge.
   task automatic send(input logic [15:0] v);
      int n;
      n = 0;
      while (!tb_in_ready && n < 200) begin
         cyc();
         n++;
      end
      if (n >= 200) chk("send_timeout", n, 0);
      tb_in       = v;
      tb_in_valid = 1'b1;
      cyc();
      tb_in_valid = 1'b0;
      tb_in       = 16'($urandom);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || tb_out_valid) && n < 500) begin
         cyc();
         n++;
      end
      if (n >= 500) chk("drain_timeout", n, 0);
   endtask

   // Output monitor: scoreboard pops, idle-value rules, stall stability.
   logic       prev_stall = 1'b0;
   logic [5:0] prev_val   = '0;
   initial begin
      logic [4:0] e;
      forever begin
         @(negedge clk);
         if (reset_n) begin
            if (prev_stall)
               chk("stall_hold", {tb_out_valid, tb_out_last, tb_out}, prev_val);
            if (tb_out_valid) begin
               chk("rdy_in_drain", tb_in_ready, 0);
               if (tb_out_ready) begin
                  if (exp_q.size() > 0) begin
                     e = exp_q.pop_front();
                     chk("out_idx_last", {tb_out_last, tb_out}, e);
                  end else begin
                     chk("unexpected_out", exp_q.size(), 1);
                  end
               end
            end else begin
               chk("idle_out_zero", {tb_out_last, tb_out}, 0);
            end
            prev_stall = tb_out_valid && !tb_out_ready;
            prev_val   = {tb_out_valid, tb_out_last, tb_out};
         end else begin
            prev_stall = 1'b0;
         end
      end
   end

   initial begin
      reset_n      = 1'b0;
      tb_in        = '0;
      tb_in_valid  = 1'b0;
      tb_out_ready = 1'b1;

      // Reset state
      #3;
      chk("rst_in_ready", tb_in_ready, 1);
      chk("rst_out_valid", tb_out_valid, 0);
      chk("rst_out", tb_out, 0);
      chk("rst_out_last", tb_out_last, 0);
      chk("rst_zero_vec", tb_zero_vec, 0);
      cyc();
      cyc();
      reset_n = 1'b1;

      // Single bit: index 0, last, one cycle after accept, then idle
      push(4'd0, 1'b1);
      send(16'h0001);
      chk("single_lat_vld", tb_out_valid, 1);
      chk("single_last", tb_out_last, 1);
      cyc();
      chk("single_idle_vld", tb_out_valid, 0);
      chk("single_idle_rdy", tb_in_ready, 1);

      // Reset to bring rr_ptr back to 0
      reset_n = 1'b0;
      cyc();
      reset_n = 1'b1;

      // 8421 from ptr 0: 0,5,10,15 back to back; in ignored while draining
      push(4'd0, 1'b0);
      push(4'd5, 1'b0);
      push(4'd10, 1'b0);
      push(4'd15, 1'b1);
      send(16'h8421);
      tb_in       = 16'hFFFF;
      tb_in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("burst_no_bubble", tb_out_valid, 1);
         cyc();
      end
      tb_in_valid = 1'b0;
      chk("burst_end_vld", tb_out_valid, 0);
      chk("burst_end_rdy", tb_in_ready, 1);
      wait_drain();

      // Pointer persistence: 0006 -> 1,2 (ptr 3), then 0009 -> 3,0
      push(4'd1, 1'b0);
      push(4'd2, 1'b1);
      send(16'h0006);
      wait_drain();
      push(4'd3, 1'b0);
      push(4'd0, 1'b1);
      send(16'h0009);
      wait_drain();

      // FFFF from ptr 1 with out_ready toggling: 1..15 then 0 (last)
      for (int i = 1; i < 16; i++) push(4'(i), 1'b0);
      push(4'd0, 1'b1);
      send(16'hFFFF);
      for (int n = 0; n < 100 && (exp_q.size() != 0 || tb_out_valid); n++) begin
         tb_out_ready = ~tb_out_ready;
         cyc();
      end
      chk("ffff_drained", exp_q.size(), 0);
      tb_out_ready = 1'b1;
      cyc();

      // Zero vector: one-cycle pulse, stays idle
      send(16'h0000);
      chk("zero_pulse", tb_zero_vec, 1);
      chk("zero_vld", tb_out_valid, 0);
      chk("zero_rdy", tb_in_ready, 1);
      cyc();
      chk("zero_pulse_end", tb_zero_vec, 0);
      chk("zero_rdy2", tb_in_ready, 1);

      // 00F0 from ptr 1: 4,5 then reset mid-drain drops 6,7
      push(4'd4, 1'b0);
      push(4'd5, 1'b0);
      send(16'h00F0);
      cyc();
      cyc();
      reset_n = 1'b0;
      #1;
      chk("midrst_vld", tb_out_valid, 0);
      chk("midrst_out", tb_out, 0);
      chk("midrst_last", tb_out_last, 0);
      chk("midrst_rdy", tb_in_ready, 1);
      chk("midrst_q", exp_q.size(), 0);
      cyc();
      reset_n = 1'b1;

      // First edge after release accepts; ptr is 0 again so 0008 -> 3
      push(4'd3, 1'b1);
      send(16'h0008);
      chk("post_rst_vld", tb_out_valid, 1);
      chk("post_rst_idx", tb_out, 3);
      wait_drain();
      for (int i = 0; i < 5; i++) cyc();
      chk("final_q_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
